apb_master: RTL and testbench

Single-channel APB master that converts a simple valid/ready command interface into APB SETUP/ACCESS transfers toward a peripheral such as the on-chip APB memory slave. It holds each transfer until the slave returns _PREADY, then presents the read data, the error status and a timeout flag on a response channel. It also keeps saturating transfer and error counters. It sits between a test or DMA agent and the APB slave select/enable lines.

---
 rtl/apb_master.sv | 197 +++++++++++++++++++
 tb/tb_apb_master.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/apb_master.sv
// apb_master: turns a valid/ready command into one APB SETUP/ACCESS transfer,
// waits for _PREADY (or an optional timeout), then returns a response on a
// valid/ready channel. Keeps saturating counts of transfers and errors.
// Every output comes straight from a register.
module apb_master #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        _PCLK,
    input  logic        _PRESETn,
    // command channel
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    // response channel
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        rsp_timeout,
    // APB side
    output logic        _PSEL1,
    output logic        _PENABLE,
    output logic        _PWRITE,
    output logic [31:0] _PADDR,
    output logic [31:0] _PWDATA,
    input  logic [31:0] _PRDATA,
    input  logic        _PREADY,
    input  logic        _PSLVERR,
    // statistics
    output logic [15:0] xfer_count,
    output logic [7:0]  err_count
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    // Timeout limit as a 16-bit value; zero means "wait forever".
    localparam logic [15:0] TO_LIM = TIMEOUT[15:0];
    localparam logic        TO_EN  = (TIMEOUT != 0);

    state_t      state_q,       state_d;
    logic        cmd_ready_q,   cmd_ready_d;
    logic        psel_q,        psel_d;
    logic        penable_q,     penable_d;
    logic        pwrite_q,      pwrite_d;
    logic [31:0] paddr_q,       paddr_d;
    logic [31:0] pwdata_q,      pwdata_d;
    logic        rsp_valid_q,   rsp_valid_d;
    logic [31:0] rsp_rdata_q,   rsp_rdata_d;
    logic        rsp_err_q,     rsp_err_d;
    logic        rsp_timeout_q, rsp_timeout_d;
    logic [15:0] tcnt_q,        tcnt_d;
    logic [15:0] xfer_q,        xfer_d;
    logic [7:0]  errc_q,        errc_d;
    logic [15:0] tcnt_inc_s;
    logic        done_s;

    assign tcnt_inc_s = tcnt_q + 16'd1;

    // Next-state, captured response and bus-control values for the next edge.
    always_comb begin
        state_d       = state_q;
        pwrite_d      = pwrite_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;
        tcnt_d        = tcnt_q;
        xfer_d        = xfer_q;
        errc_d        = errc_q;
        done_s        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // cmd_ready_q gates acceptance so a command is only taken
                // when the requester has actually seen ready high.
                if (cmd_valid && cmd_ready_q) begin
                    state_d  = ST_SETUP;
                    pwrite_d = cmd_write;
                    paddr_d  = cmd_addr;
                    pwdata_d = cmd_wdata;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
                tcnt_d  = 16'd0;
            end
            ST_ACCESS: begin
                // _PREADY is checked first so it wins over a coincident timeout.
                if (_PREADY) begin
                    state_d       = ST_RESP;
                    rsp_rdata_d   = pwrite_q ? 32'd0 : _PRDATA;
                    rsp_err_d     = _PSLVERR;
                    rsp_timeout_d = 1'b0;
                    done_s        = 1'b1;
                end else if (TO_EN && (tcnt_inc_s == TO_LIM)) begin
                    state_d       = ST_RESP;
                    rsp_rdata_d   = 32'd0;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                    done_s        = 1'b1;
                end else if (TO_EN) begin
                    tcnt_d = tcnt_inc_s;
                end else begin
                    tcnt_d = tcnt_q;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Counters move together on the edge the response is produced.
        if (done_s) begin
            xfer_d = (xfer_q == 16'hFFFF) ? xfer_q : (xfer_q + 16'd1);
            if (rsp_err_d && (errc_q != 8'hFF)) begin
                errc_d = errc_q + 8'd1;
            end else begin
                errc_d = errc_q;
            end
        end else begin
            xfer_d = xfer_q;
            errc_d = errc_q;
        end

        // Registered handshake/bus strobes are decoded from the next state.
        cmd_ready_d = (state_d == ST_IDLE);
        psel_d      = (state_d == ST_SETUP) || (state_d == ST_ACCESS);
        penable_d   = (state_d == ST_ACCESS);
        rsp_valid_d = (state_d == ST_RESP);
    end

    // State and output registers; asynchronous reset abandons any transfer.
    always_ff @(posedge _PCLK or negedge _PRESETn) begin
        if (!_PRESETn) begin
            state_q       <= ST_IDLE;
            cmd_ready_q   <= 1'b0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= 32'd0;
            pwdata_q      <= 32'd0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= 32'd0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            tcnt_q        <= 16'd0;
            xfer_q        <= 16'd0;
            errc_q        <= 8'd0;
        end else begin
            state_q       <= state_d;
            cmd_ready_q   <= cmd_ready_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
            tcnt_q        <= tcnt_d;
            xfer_q        <= xfer_d;
            errc_q        <= errc_d;
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign _PSEL1      = psel_q;
    assign _PENABLE    = penable_q;
    assign _PWRITE     = pwrite_q;
    assign _PADDR      = paddr_q;
    assign _PWDATA     = pwdata_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;
    assign xfer_count  = xfer_q;
    assign err_count   = errc_q;

endmodule

// File: tb/tb_apb_master.sv
// Testbench for apb_master: the bench plays an APB memory slave with a
// programmable number of wait states and checks every transfer against
// expectations derived from the transfer's parameters.
module tb_apb_master;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rstn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata, prdata;
    logic        pready, pslverr;
    logic [15:0] xfer_count;
    logic [7:0]  err_count;

    always #5 clk = ~clk;

    apb_master #(.TIMEOUT(TO)) dut (
        ._PCLK(clk), ._PRESETn(rstn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        ._PSEL1(psel), ._PENABLE(penable), ._PWRITE(pwrite),
        ._PADDR(paddr), ._PWDATA(pwdata), ._PRDATA(prdata),
        ._PREADY(pready), ._PSLVERR(pslverr),
        .xfer_count(xfer_count), .err_count(err_count)
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] mem [logic [31:0]];
    int exp_xfer = 0;
    int exp_errc = 0;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          waits;
        logic        slverr;
        int          hold;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic        exp_tmo;
        int          exp_lat;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    // One complete transfer. Called at a negedge; returns at a negedge in IDLE.
    // Latency is counted in negedges after the accepting posedge.
    task automatic do_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input int waits, input logic slverr, input int hold,
                           input logic [31:0] exp_rdata, input logic exp_err,
                           input logic exp_tmo, input int exp_lat);
        int c;
        bit ok;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
        ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (cmd_ready) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        chk("cmd_accept", 32'(ok), 32'd1);
        if (!ok) begin cmd_valid = 1'b0; return; end
        @(negedge clk);
        cmd_valid = 1'b0; cmd_write = 1'($urandom); cmd_addr = $urandom; cmd_wdata = $urandom;
        c = 1; ok = 1'b0;
        while (c < 64) begin
            if (rsp_valid) begin ok = 1'b1; break; end
            chk("psel_busy", 32'(psel), 32'd1);
            chk("penable_phase", 32'(penable), 32'(c >= 2));
            chk("paddr_stable", paddr, addr);
            chk("pwrite_stable", 32'(pwrite), 32'(wr));
            chk("pwdata_stable", pwdata, wdata);
            chk("cmd_ready_busy", 32'(cmd_ready), 32'd0);
            if (c >= 2 && (c - 2) == waits) begin
                pready = 1'b1; pslverr = slverr;
                prdata = wr ? $urandom : mem_rd(addr);
                if (wr && !slverr) mem[addr] = wdata;
            end else begin
                pready = 1'b0; pslverr = 1'($urandom); prdata = $urandom;
            end
            @(negedge clk);
            c++;
        end
        pready = 1'b0; pslverr = 1'b0;
        chk("rsp_arrive", 32'(ok), 32'd1);
        if (!ok) return;
        chk("latency", 32'(c), 32'(exp_lat));
        exp_xfer = (exp_xfer == 65535) ? exp_xfer : exp_xfer + 1;
        if (exp_err) exp_errc = (exp_errc == 255) ? exp_errc : exp_errc + 1;
        for (int h = 0; h <= hold; h++) begin
            chk("rsp_valid", 32'(rsp_valid), 32'd1);
            chk("rsp_rdata", rsp_rdata, exp_rdata);
            chk("rsp_err", 32'(rsp_err), 32'(exp_err));
            chk("rsp_timeout", 32'(rsp_timeout), 32'(exp_tmo));
            chk("psel_resp", 32'(psel), 32'd0);
            chk("penable_resp", 32'(penable), 32'd0);
            chk("cmd_ready_resp", 32'(cmd_ready), 32'd0);
            chk("xfer_count", 32'(xfer_count), 32'(exp_xfer));
            chk("err_count", 32'(err_count), 32'(exp_errc));
            if (h == hold) rsp_ready = 1'b1;
            @(negedge clk);
        end
        rsp_ready = 1'b0;
        chk("rsp_valid_idle", 32'(rsp_valid), 32'd0);
        chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        chk("psel_idle", 32'(psel), 32'd0);
        chk("paddr_idle_hold", paddr, addr);
        chk("xfer_count_idle", 32'(xfer_count), 32'(exp_xfer));
    endtask

    initial begin
        vec_t tbl[8];
        bit ok;
        tbl[0] = '{1'b1, 32'h04, 32'hA5A5_0001, 0,  1'b0, 0, 32'h0,         1'b0, 1'b0, 3};
        tbl[1] = '{1'b0, 32'h04, 32'h0,         3,  1'b0, 0, 32'hA5A5_0001, 1'b0, 1'b0, 6};
        tbl[2] = '{1'b0, 32'h40, 32'h0,         0,  1'b1, 0, 32'h0,         1'b1, 1'b0, 3};
        tbl[3] = '{1'b0, 32'h08, 32'h0,         16, 1'b0, 0, 32'h0,         1'b1, 1'b1, 18};
        tbl[4] = '{1'b1, 32'h08, 32'h1234_5678, 15, 1'b0, 5, 32'h0,         1'b0, 1'b0, 18};
        tbl[5] = '{1'b0, 32'h08, 32'h0,         0,  1'b0, 2, 32'h1234_5678, 1'b0, 1'b0, 3};
        tbl[6] = '{1'b1, 32'h0C, 32'hDEAD_BEEF, 1,  1'b1, 1, 32'h0,         1'b1, 1'b0, 4};
        tbl[7] = '{1'b0, 32'h0C, 32'h0,         0,  1'b0, 0, 32'h0,         1'b0, 1'b0, 3};

        rstn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'h0; cmd_wdata = 32'h0;
        rsp_ready = 1'b0; prdata = 32'h0; pready = 1'b0; pslverr = 1'b0;
        #1;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_psel", 32'(psel), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_paddr", paddr, 32'd0);
        chk("rst_counts", {8'd0, err_count, xfer_count}, 32'd0);
        @(negedge clk); @(negedge clk);
        rstn = 1'b1;
        chk("cmd_ready_after_rst", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        chk("cmd_ready_idle_start", 32'(cmd_ready), 32'd1);

        // Directed vectors
        for (int i = 0; i < 8; i++) begin
            do_xfer(tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].waits, tbl[i].slverr,
                    tbl[i].hold, tbl[i].exp_rdata, tbl[i].exp_err, tbl[i].exp_tmo, tbl[i].exp_lat);
        end

        // Reset pulsed in the middle of ACCESS
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h20; cmd_wdata = 32'h5555_AAAA;
        ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (cmd_ready) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        chk("rst_seq_accept", 32'(ok), 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("rst_seq_access", 32'(penable), 32'd1);
        #2 rstn = 1'b0;
        #1;
        chk("midrst_psel", 32'(psel), 32'd0);
        chk("midrst_penable", 32'(penable), 32'd0);
        chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midrst_xfer", 32'(xfer_count), 32'd0);
        chk("midrst_err", 32'(err_count), 32'd0);
        #1 rstn = 1'b1;
        exp_xfer = 0; exp_errc = 0;
        @(negedge clk);
        do_xfer(1'b0, 32'h04, 32'h0, 1, 1'b0, 0, 32'hA5A5_0001, 1'b0, 1'b0, 4);

        // Randomized transfers against the reference model
        for (int n = 0; n < 40; n++) begin
            logic        wr, se, tmo, err;
            logic [31:0] a, wd, rd;
            int          w, hd, lat;
            wr = 1'($urandom);
            a  = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
            wd = $urandom;
            w  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(14, 18)) : int'($urandom_range(0, 3));
            se = ($urandom_range(0, 3) == 0);
            hd = $urandom_range(0, 3);
            tmo = (w >= TO);
            err = tmo | se;
            rd  = (tmo || wr) ? 32'h0 : mem_rd(a);
            lat = tmo ? TO + 2 : w + 3;
            do_xfer(wr, a, wd, w, se, hd, rd, err, tmo, lat);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
